cis_control: RTL and testbench
==============================

CIS_CONTROL -- requirements
Module: cis_control

Interface
REQ-001 Parameter NUM_SIGNALS, default 11, number of output control lines.
REQ-002 Parameter PATTERN_LEN, default 12, pattern length in pattern steps.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port integration, input, 1 bit: asynchronous exposure request; high means exposing.
REQ-006 Port pattern_ccd_reset, input, NUM_SIGNALS x PATTERN_LEN packed, [sig][step]: idle/clear pattern.
REQ-007 Port pattern_integration, input, same shape: charge-transfer pattern played once per exposure.
REQ-008 Port pattern_skipping, input, same shape: skipper-readout pattern played skip_samples times.
REQ-009 Port clk_div, input, 10 bits: clk cycles per pattern step; value 0 SHALL be treated as 1.
REQ-010 Port skip_samples, input, 10 bits: number of skipping-pattern repetitions per readout.
REQ-011 Port signal, output, NUM_SIGNALS bits: registered control levels.
REQ-012 Port running, output, 1 bit: high during transfer and skipping.

Function
REQ-013 A prescaler SHALL count 0..clk_div-1 and assert a one-cycle tick when the count equals clk_div-1; the prescaler runs free in all states.
REQ-014 Bit step of pattern[k] SHALL drive signal[k] for that step; step 0 is the LSB and is played first.
REQ-015 On each tick in a pattern-playing state, signal SHALL load the current step's column and step SHALL advance; after step PATTERN_LEN-1, step wraps to 0 and the end-of-pattern decision is taken.
REQ-016 The integration input SHALL pass through a two-flop synchronizer before use.
REQ-017 State CLEAR SHALL loop pattern_ccd_reset; at end of pattern, if synced integration=1, go to EXPOSE, else replay CLEAR.
REQ-018 State EXPOSE SHALL hold signal at all zeros; on the first tick with synced integration=0, go to TRANSFER with step=0.
REQ-019 State TRANSFER SHALL play pattern_integration once; at its end, go to SKIP if the latched skip count is greater than 0, else go to CLEAR.
REQ-020 State SKIP SHALL play pattern_skipping; a repetition counter SHALL increment per completed pattern, and after skip_samples repetitions the FSM returns to CLEAR.
REQ-021 clk_div and skip_samples SHALL be latched on entry to TRANSFER; changes mid-readout have no effect until the next readout.
REQ-022 running SHALL be a registered output, 1 exactly while state is TRANSFER or SKIP.
REQ-023 An integration pulse that is high and falls again within one CLEAR pattern SHALL be ignored; the integration pulse width MUST exceed one CLEAR pattern period.
REQ-024 A rising edge of integration during TRANSFER or SKIP SHALL NOT abort the readout; it is acted on at the next CLEAR pattern end.

Reset
REQ-025 While reset is high: state=CLEAR, step=0, prescaler=0, repetition counter=0, synchronizer=0, signal=0, running=0.
REQ-026 Reset asserted mid-readout SHALL abort immediately; the first tick after release plays pattern_ccd_reset step 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (CLEAR, EXPOSE, TRANSFER, SKIP) and the 10-bit width constant for clk_div and skip_samples.
REQ-028 One sub-module, cis_tick_gen (prescaler with divide-by-0-as-1 handling), SHALL be used; the FSM and pattern mux are inline.

Verification
REQ-029 Reset with integration=0, clk_div=4: signal[0] stays 1 and signal[6] is 1 for steps 0-3 of each 48-clock CLEAR loop; running=0.
REQ-030 integration high for 200 clocks, then low: EXPOSE gives signal=0; after the fall, running=1 within sync+4 clocks and the TRANSFER steps are held 4 clocks each.
REQ-031 skip_samples=10, clk_div=4, PATTERN_LEN=12: running stays high for 48 TRANSFER clocks + 480 SKIP clocks (±1 step of alignment), then drops; CLEAR resumes.
REQ-032 skip_samples=0: after TRANSFER, go directly to CLEAR; running is high for 48 clocks only.
REQ-033 clk_div=0: steps advance every clock, identical to clk_div=1.
REQ-034 Reset pulsed during SKIP: signal=0 and running=0 asynchronously; CLEAR restarts at step 0.

Source files
------------

// File: rtl/cis_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cis_control_pkg
//  Description : Shared types and constants for the CIS (CCD image sensor)
//                clock/pattern controller.
//                  - cis_state_t : sequencer states CLEAR, EXPOSE, TRANSFER,
//                                  SKIP
//                  - c_CFG_W     : width of the clk_div and skip_samples
//                                  configuration words
//  Revision    : 1.0  initial release
// ============================================================================
package cis_control_pkg;

    // Width of the clk_div and skip_samples configuration inputs.
    localparam int c_CFG_W = 10;

    // Sequencer states.
    //   CLEAR    : loop the idle/clear pattern, waiting for an exposure request
    //   EXPOSE   : all control lines low while charge integrates
    //   TRANSFER : play the charge-transfer pattern once
    //   SKIP     : play the skipper-readout pattern skip_samples times
    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        EXPOSE   = 2'd1,
        TRANSFER = 2'd2,
        SKIP     = 2'd3
    } cis_state_t;

endpackage : cis_control_pkg
`default_nettype wire

// File: rtl/cis_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cis_tick_gen
//  Description : Free-running prescaler producing the pattern-step tick.
//                The counter runs 0 .. i_div-1 and o_tick is high for the one
//                cycle in which the count equals i_div-1. A divisor of 0 is
//                handled as 1, so the tick is then high every cycle.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-high reset (count -> 0)
//                i_div    - clk cycles per tick (0 treated as 1)
//                o_tick   - one-cycle step strobe
//  Revision    : 1.0  initial release
// ============================================================================
module cis_tick_gen
    import cis_control_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [c_CFG_W-1:0] i_div,
    output logic               o_tick
);

    logic [c_CFG_W-1:0] r_cnt;
    logic [c_CFG_W-1:0] w_last;

    // Terminal count; a zero divisor collapses onto divide-by-one.
    assign w_last = (i_div == '0) ? '0 : (i_div - c_CFG_W'(1));

    assign o_tick = (r_cnt == w_last);

    // ">=" rather than "==" so that a divisor lowered below the current
    // count (possible in CLEAR, where the divisor is live) wraps at once
    // instead of running through the whole counter range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CFG_W'(1);
        end
    end

endmodule : cis_tick_gen
`default_nettype wire

// File: rtl/cis_control.sv
`default_nettype none
// ============================================================================
//  Module      : cis_control
//  Description : CCD image-sensor control sequencer. Plays bit-pattern
//                "waveforms" onto NUM_SIGNALS control lines, one pattern step
//                per prescaler tick:
//                  CLEAR    loops pattern_ccd_reset until an exposure request
//                  EXPOSE   holds all lines low while integration is high
//                  TRANSFER plays pattern_integration once
//                  SKIP     plays pattern_skipping skip_samples times
//                Patterns are packed [signal][step]; step 0 (LSB) plays first.
//  Ports       : clk                 - clock, rising edge
//                reset               - asynchronous active-high reset
//                integration         - async exposure request (1 = exposing)
//                pattern_ccd_reset   - idle/clear pattern
//                pattern_integration - charge-transfer pattern
//                pattern_skipping    - skipper-readout pattern
//                clk_div             - clk cycles per pattern step (0 -> 1)
//                skip_samples        - skipping-pattern repetitions per readout
//                signal              - registered control-line levels
//                running             - registered, high in TRANSFER and SKIP
//  Revision    : 1.0  initial release
// ============================================================================
module cis_control
    import cis_control_pkg::*;
#(
    parameter int NUM_SIGNALS = 11,
    parameter int PATTERN_LEN = 12
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   integration,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_ccd_reset,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_integration,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_skipping,
    input  logic [c_CFG_W-1:0]                     clk_div,
    input  logic [c_CFG_W-1:0]                     skip_samples,
    output logic [NUM_SIGNALS-1:0]                 signal,
    output logic                                   running
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int c_STEP_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(PATTERN_LEN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    cis_state_t                        r_state;
    logic [c_STEP_W-1:0]               r_step;
    logic [c_CFG_W-1:0]                r_rep;       // completed SKIP patterns
    logic [c_CFG_W-1:0]                r_div_lat;   // clk_div for this readout
    logic [c_CFG_W-1:0]                r_skip_lat;  // skip_samples for this readout
    logic                              r_sync1;
    logic                              r_sync2;     // synchronized integration
    logic [NUM_SIGNALS-1:0]            r_signal;
    logic                              r_running;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                                    w_tick;
    logic [c_CFG_W-1:0]                      w_div;
    logic                                    w_last_step;
    logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] w_pat;
    logic [NUM_SIGNALS-1:0]                  w_col;

    // During a readout the prescaler follows the divisor captured on entry
    // to TRANSFER, so clk_div may be rewritten freely while a readout runs.
    // r_running is high exactly in TRANSFER/SKIP, so it doubles as select.
    assign w_div = r_running ? r_div_lat : clk_div;

    assign w_last_step = (r_step == c_LAST_STEP);

    cis_tick_gen u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    // Pattern mux: pick the pattern belonging to the current state, then
    // take bit r_step of each signal row to form the column to drive.
    always_comb begin
        w_pat = '0;
        case (r_state)
            CLEAR:    w_pat = pattern_ccd_reset;
            TRANSFER: w_pat = pattern_integration;
            SKIP:     w_pat = pattern_skipping;
            default:  w_pat = '0;
        endcase

        w_col = '0;
        for (int k = 0; k < NUM_SIGNALS; k++) begin
            w_col[k] = w_pat[k][r_step];
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // All pattern activity happens on prescaler ticks. The column for the
    // current step is loaded and the step advances in the same tick; the
    // end-of-pattern decision is made on the tick that loads the last step,
    // so that column is still held for a full step period afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= CLEAR;
            r_step     <= '0;
            r_rep      <= '0;
            r_div_lat  <= '0;
            r_skip_lat <= '0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_signal   <= '0;
            r_running  <= 1'b0;
        end else begin
            // Two-flop synchronizer for the asynchronous exposure request.
            r_sync1 <= integration;
            r_sync2 <= r_sync1;

            if (w_tick) begin
                case (r_state)
                    CLEAR: begin
                        // The request is only sampled at pattern end, so a
                        // pulse that comes and goes inside one CLEAR pattern
                        // never starts an exposure.
                        r_signal <= w_col;
                        if (w_last_step) begin
                            r_step <= '0;
                            if (r_sync2) begin
                                r_state <= EXPOSE;
                            end
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end

                    EXPOSE: begin
                        r_signal <= '0;
                        r_step   <= '0;
                        if (!r_sync2) begin
                            r_state    <= TRANSFER;
                            r_running  <= 1'b1;
                            r_div_lat  <= clk_div;
                            r_skip_lat <= skip_samples;
                        end
                    end

                    TRANSFER: begin
                        r_signal <= w_col;
                        if (w_last_step) begin
                            r_step <= '0;
                            r_rep  <= '0;
                            if (r_skip_lat != '0) begin
                                r_state <= SKIP;
                            end else begin
                                r_state   <= CLEAR;
                                r_running <= 1'b0;
                            end
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end

                    SKIP: begin
                        r_signal <= w_col;
                        if (w_last_step) begin
                            r_step <= '0;
                            if ((r_rep + c_CFG_W'(1)) == r_skip_lat) begin
                                r_rep     <= '0;
                                r_state   <= CLEAR;
                                r_running <= 1'b0;
                            end else begin
                                r_rep <= r_rep + c_CFG_W'(1);
                            end
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end

                    default: begin
                        r_state   <= CLEAR;
                        r_step    <= '0;
                        r_signal  <= '0;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign signal  = r_signal;
    assign running = r_running;

endmodule : cis_control
`default_nettype wire

// File: tb/tb_cis_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cis_control
//  Description : Directed self-checking bench for cis_control
//                (NUM_SIGNALS=11, PATTERN_LEN=12). Reset is released on a
//                falling edge, so "edge e" below is the e-th rising edge after
//                release; outputs are sampled on the falling edge after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cis_control;

    localparam int NS = 11;
    localparam int PL = 12;

    logic                   clk;
    logic                   reset;
    logic                   integration;
    logic [NS-1:0][PL-1:0]  pat_ccd;
    logic [NS-1:0][PL-1:0]  pat_int;
    logic [NS-1:0][PL-1:0]  pat_skip;
    logic [9:0]             clk_div;
    logic [9:0]             skip_samples;
    logic [NS-1:0]          signal;
    logic                   running;

    int checks = 0;
    int errors = 0;

    cis_control #(
        .NUM_SIGNALS (NS),
        .PATTERN_LEN (PL)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .integration         (integration),
        .pattern_ccd_reset   (pat_ccd),
        .pattern_integration (pat_int),
        .pattern_skipping    (pat_skip),
        .clk_div             (clk_div),
        .skip_samples        (skip_samples),
        .signal              (signal),
        .running             (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column of a pattern at a given step: bit s of every signal row.
    function automatic logic [NS-1:0] col(input logic [NS-1:0][PL-1:0] p, input int s);
        logic [NS-1:0] c;
        for (int k = 0; k < NS; k++) c[k] = p[k][s];
        return c;
    endfunction

    // Expected CLEAR output e edges after release with a divide-by-4 tick.
    function automatic logic [NS-1:0] clear4(input int e);
        if (e < 4) return '0;
        return col(pat_ccd, ((e / 4) - 1) % PL);
    endfunction

    // Assert reset for three clocks, check the reset state, release on a
    // falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (signal !== '0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: signal=%h running=%b expected signal=0 running=0", signal, running);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clk_div = 10'd4; skip_samples = 10'd0; integration = 1'b0;
        do_reset();
    endtask

    // Idle CLEAR loop: signal[0] always 1, signal[6] high on steps 0-3.
    task automatic test_clear_loop();
        clk_div = 10'd4; integration = 1'b0;
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            checks++;
            if (signal !== clear4(e) || running !== 1'b0) begin
                errors++;
                $display("FAIL clear_loop edge %0d: signal=%h running=%b expected %h 0", e, signal, running, clear4(e));
            end
            if (e >= 4) begin
                checks++;
                if (signal[0] !== 1'b1 || signal[6] !== ((((e / 4) - 1) % PL) < 4)) begin
                    errors++;
                    $display("FAIL clear_sig0_sig6 edge %0d: sig0=%b sig6=%b", e, signal[0], signal[6]);
                end
            end
        end
    endtask

    // clk_div 0 and 1 must both step every clock.
    task automatic test_div0();
        for (int d = 0; d <= 1; d++) begin
            clk_div = 10'(d); integration = 1'b0;
            do_reset();
            for (int e = 1; e <= 30; e++) begin
                @(negedge clk);
                checks++;
                if (signal !== col(pat_ccd, (e - 1) % PL)) begin
                    errors++;
                    $display("FAIL div%0d edge %0d: signal=%h expected %h", d, e, signal, col(pat_ccd, (e - 1) % PL));
                end
            end
        end
    endtask

    // A request that rises and falls inside one CLEAR pattern is ignored.
    task automatic test_short_pulse();
        clk_div = 10'd4; integration = 1'b0;
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            checks++;
            if (signal !== clear4(e) || running !== 1'b0) begin
                errors++;
                $display("FAIL short_pulse edge %0d: signal=%h running=%b expected %h 0", e, signal, running, clear4(e));
            end
            if (e == 10) integration = 1'b1;
            if (e == 30) integration = 1'b0;
        end
    endtask

    // Full exposure + readout, skip_samples=10, clk_div=4.
    //  edge 48 : CLEAR end, request seen -> EXPOSE; edge 52 drives zeros
    //  integration falls after edge 200 -> synced low at 202 -> TRANSFER @204
    //  TRANSFER steps at 208..252, SKIP 10 x 48 clocks at 256..732 -> CLEAR
    //  request re-raised at 300 mid-readout: acted on at CLEAR end (edge 780)
    //  clk_div/skip_samples rewritten mid-readout must have no effect
    task automatic test_readout();
        logic [NS-1:0] exp_sig;
        logic          exp_run;
        int            run_cnt;
        clk_div = 10'd4; skip_samples = 10'd10; integration = 1'b1;
        do_reset();
        run_cnt = 0;
        for (int e = 1; e <= 800; e++) begin
            @(negedge clk);
            if (e < 52)       exp_sig = clear4(e);
            else if (e < 208) exp_sig = '0;
            else if (e < 256) exp_sig = col(pat_int, (e - 208) / 4);
            else if (e < 736) exp_sig = col(pat_skip, ((e - 256) / 4) % PL);
            else if (e < 784) exp_sig = col(pat_ccd, (e - 736) / 4);
            else              exp_sig = '0;
            exp_run = (e >= 204) && (e <= 731);
            if (running === 1'b1 && e > 200) run_cnt++;
            checks++;
            if (signal !== exp_sig || running !== exp_run) begin
                errors++;
                $display("FAIL readout edge %0d: signal=%h running=%b expected %h %b", e, signal, running, exp_sig, exp_run);
            end
            if (e == 200) integration = 1'b0;
            if (e == 300) integration = 1'b1;
            if (e == 400) begin clk_div = 10'd1; skip_samples = 10'd3; end
            if (e == 700) clk_div = 10'd4;
        end
        checks++;
        if (run_cnt != 528) begin
            errors++;
            $display("FAIL readout_running_len: got %0d clocks expected 528", run_cnt);
        end
    endtask

    // skip_samples=0: TRANSFER goes straight back to CLEAR after 48 clocks.
    //  request falls after edge 52 -> synced low at 54 -> TRANSFER @56
    //  TRANSFER steps 60..104, CLEAR from edge 108
    task automatic test_skip_zero();
        logic [NS-1:0] exp_sig;
        logic          exp_run;
        int            run_cnt;
        clk_div = 10'd4; skip_samples = 10'd0; integration = 1'b1;
        do_reset();
        run_cnt = 0;
        for (int e = 1; e <= 160; e++) begin
            @(negedge clk);
            if (e < 52)       exp_sig = clear4(e);
            else if (e < 60)  exp_sig = '0;
            else if (e < 108) exp_sig = col(pat_int, (e - 60) / 4);
            else              exp_sig = col(pat_ccd, ((e - 108) / 4) % PL);
            exp_run = (e >= 56) && (e <= 103);
            if (running === 1'b1) run_cnt++;
            checks++;
            if (signal !== exp_sig || running !== exp_run) begin
                errors++;
                $display("FAIL skip_zero edge %0d: signal=%h running=%b expected %h %b", e, signal, running, exp_sig, exp_run);
            end
            if (e == 52) integration = 1'b0;
        end
        checks++;
        if (run_cnt != 48) begin
            errors++;
            $display("FAIL skip_zero_running_len: got %0d clocks expected 48", run_cnt);
        end
    endtask

    // Reset in the middle of SKIP clears outputs at once; CLEAR restarts
    // at step 0 on the first tick after release.
    task automatic test_reset_during_skip();
        clk_div = 10'd4; skip_samples = 10'd5; integration = 1'b1;
        do_reset();
        for (int e = 1; e <= 130; e++) begin
            @(negedge clk);
            if (e == 52) integration = 1'b0;
        end
        checks++;
        if (running !== 1'b1 || signal !== col(pat_skip, 5)) begin
            errors++;
            $display("FAIL skip_before_reset: signal=%h running=%b expected %h 1", signal, running, col(pat_skip, 5));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (signal !== '0 || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: signal=%h running=%b expected 0 0", signal, running);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            checks++;
            if (signal !== clear4(e) || running !== 1'b0) begin
                errors++;
                $display("FAIL restart edge %0d: signal=%h running=%b expected %h 0", e, signal, running, clear4(e));
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        integration  = 1'b0;
        clk_div      = 10'd4;
        skip_samples = 10'd0;
        pat_ccd  = '0;
        pat_int  = '0;
        pat_skip = '0;
        pat_ccd[0]  = 12'hFFF;
        pat_ccd[1]  = 12'hA5A;
        pat_ccd[6]  = 12'h00F;
        pat_int[3]  = 12'h0F0;
        pat_int[4]  = 12'h001;
        pat_int[10] = 12'hFFE;
        pat_skip[2] = 12'h0C3;
        pat_skip[5] = 12'h555;
        pat_skip[7] = 12'h800;

        test_reset();
        test_clear_loop();
        test_div0();
        test_short_pulse();
        test_readout();
        test_skip_zero();
        test_reset_during_skip();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cis_control
`default_nettype wire
